// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline.
// Load-use bubbles, taken-branch flushes, memory-wait freeze, counters, watchdog.
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64,
    parameter int WAIT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_load,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             hazard_detection,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             memwb_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout,
    output logic             waiting
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              rs1_hit;
    logic              rs2_hit;
    logic              lu;
    logic              frz;

    assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    assign lu      = ex_load && (ex_rd != 5'd0) && (rs1_hit || rs2_hit);
    assign frz     = mem_req && !mem_ready;

    // State register: reset aborts any pending wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and pipeline controls; freeze beats branch beats load-use.
    always_comb begin
        state_nx         = frz ? S_WAIT : S_RUN;
        pc_write         = 1'b1;
        ifid_write       = 1'b1;
        ifid_flush       = 1'b0;
        hazard_detection = 1'b0;
        idex_hold        = 1'b0;
        exmem_hold       = 1'b0;
        memwb_hold       = 1'b0;
        waiting          = (state == S_WAIT) && !rst;
        if (rst) begin
            state_nx = S_RUN;
        end else if (frz) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
            memwb_hold = 1'b1;
        end else if (br_taken) begin
            ifid_flush       = 1'b1;
            hazard_detection = 1'b1;
        end else if (lu) begin
            pc_write         = 1'b0;
            ifid_write       = 1'b0;
            hazard_detection = 1'b1;
        end
    end

    // Consecutive freeze counter and sticky watchdog flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (frz) begin
            if (wait_cnt != '1) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (wait_cnt >= WAIT_LAST) begin
                mem_timeout <= 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end

    // Saturating stall and flush performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((frz || (lu && !br_taken)) && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (br_taken && !frz && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: default instance plus a small one (CNT_W=2, TIMEOUT=4).
// Behavioural model checked every negedge, plus directed literal checks.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_use_rs1, id_use_rs2, ex_load, br_taken, mem_req, mem_ready;

    logic a_pc, a_ifw, a_fl, a_hz, a_ih, a_eh, a_mh, a_to, a_wt;
    logic [15:0] a_stall, a_flush;
    logic b_pc, b_ifw, b_fl, b_hz, b_ih, b_eh, b_mh, b_to, b_wt;
    logic [1:0] b_stall, b_flush;

    int total = 0;
    int bad   = 0;
    bit armed = 0;

    int m_stall, m_flush, m_consec;
    bit m_to_a, m_to_b;

    always #5 clk = ~clk;

    hazard_ctrl u0 (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_load(ex_load), .br_taken(br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(a_pc), .ifid_write(a_ifw), .ifid_flush(a_fl),
        .hazard_detection(a_hz), .idex_hold(a_ih), .exmem_hold(a_eh),
        .memwb_hold(a_mh), .stall_cnt(a_stall), .flush_cnt(a_flush),
        .mem_timeout(a_to), .waiting(a_wt)
    );

    hazard_ctrl #(.CNT_W(2), .TIMEOUT(4), .WAIT_W(3)) u1 (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_load(ex_load), .br_taken(br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(b_pc), .ifid_write(b_ifw), .ifid_flush(b_fl),
        .hazard_detection(b_hz), .idex_hold(b_ih), .exmem_hold(b_eh),
        .memwb_hold(b_mh), .stall_cnt(b_stall), .flush_cnt(b_flush),
        .mem_timeout(b_to), .waiting(b_wt)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_lu();
        bit hit;
        hit = (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
        return ex_load && (ex_rd != 0) && hit;
    endfunction

    function automatic bit m_frz();
        return mem_req && !mem_ready;
    endfunction

    // {pc_write, ifid_write, ifid_flush, hazard_detection, idex, exmem, memwb}
    function automatic logic [6:0] m_ctl();
        if (rst)           return 7'b1100000;
        if (m_frz())       return 7'b0000111;
        if (br_taken)      return 7'b1111000;
        if (m_lu())        return 7'b0001000;
        return 7'b1100000;
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Model state advances on each posedge from the inputs then present.
    always @(posedge clk) begin
        if (rst) begin
            m_stall = 0; m_flush = 0; m_consec = 0;
            m_to_a = 0; m_to_b = 0;
        end else begin
            if (m_frz() || (m_lu() && !br_taken)) m_stall++;
            if (br_taken && !m_frz()) m_flush++;
            if (m_frz()) begin
                m_consec++;
                if (m_consec >= 64) m_to_a = 1;
                if (m_consec >= 4) m_to_b = 1;
            end else begin
                m_consec = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("ctl_a", {a_pc, a_ifw, a_fl, a_hz, a_ih, a_eh, a_mh}, m_ctl());
            chk("ctl_b", {b_pc, b_ifw, b_fl, b_hz, b_ih, b_eh, b_mh}, m_ctl());
            chk("stall_a", a_stall, sat(m_stall, 16));
            chk("stall_b", b_stall, sat(m_stall, 2));
            chk("flush_a", a_flush, sat(m_flush, 16));
            chk("flush_b", b_flush, sat(m_flush, 2));
            chk("to_a", a_to, m_to_a);
            chk("to_b", b_to, m_to_b);
            chk("wait_a", a_wt, !rst && m_consec > 0);
            chk("wait_b", b_wt, !rst && m_consec > 0);
        end
    end

    task automatic drive(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1_, input logic u2_, input logic [4:0] rd,
                         input logic ld, input logic br, input logic rq, input logic rdy);
        rst = r; id_rs1 = rs1; id_rs2 = rs2;
        id_use_rs1 = u1_; id_use_rs2 = u2_;
        ex_rd = rd; ex_load = ld; br_taken = br;
        mem_req = rq; mem_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with a pending freeze on the inputs: outputs must stay forced
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        armed = 1;
        #1;
        chk("rst_pc", a_pc, 1);
        chk("rst_hold", a_eh, 0);
        chk("rst_wait", a_wt, 0);
        chk("rst_stall", a_stall, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("idle_stall", a_stall, 0);

        // load-use on rs1, one bubble
        drive(0, 5, 0, 1, 0, 5, 1, 0, 0, 0);
        #1;
        chk("lu_hz", a_hz, 1);
        chk("lu_pc", a_pc, 0);
        chk("lu_ifw", a_ifw, 0);
        tick();
        chk("lu_stall", a_stall, 1);
        drive(0, 5, 0, 1, 0, 5, 0, 0, 0, 0);
        #1;
        chk("lu_rel_pc", a_pc, 1);
        chk("lu_rel_hz", a_hz, 0);
        tick();
        chk("lu_rel_stall", a_stall, 1);

        // load-use on rs2, then same regs without use flag
        drive(0, 7, 7, 0, 1, 7, 1, 0, 0, 0);
        #1;
        chk("lu2_hz", a_hz, 1);
        tick();
        chk("lu2_stall", a_stall, 2);
        drive(0, 7, 7, 0, 0, 7, 1, 0, 0, 0);
        #1;
        chk("nouse_pc", a_pc, 1);
        tick();

        // x0 never hazards
        drive(0, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        #1;
        chk("x0_pc", a_pc, 1);
        chk("x0_hz", a_hz, 0);
        tick();
        chk("x0_stall", a_stall, 2);

        // branch beats load-use
        drive(0, 5, 0, 1, 0, 5, 1, 1, 0, 0);
        #1;
        chk("br_flush", a_fl, 1);
        chk("br_hz", a_hz, 1);
        chk("br_pc", a_pc, 1);
        tick();
        chk("br_flushcnt", a_flush, 1);
        chk("br_stall", a_stall, 2);

        // memory wait 3 cycles, branch presented but ignored
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        #1;
        chk("mw_pc", a_pc, 0);
        chk("mw_hold", a_mh, 1);
        chk("mw_flush", a_fl, 0);
        tick();
        chk("mw_wait", a_wt, 1);
        tick();
        tick();
        chk("mw_stall", a_stall, 5);
        chk("mw_flushcnt", a_flush, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        #1;
        chk("mw_rel_pc", a_pc, 1);
        chk("mw_rel_hold", a_eh, 0);
        tick();
        chk("mw_rel_wait", a_wt, 0);
        chk("mw_to", b_to, 0);
        chk("mw_stall2", a_stall, 5);

        // watchdog on small instance: freeze 6 cycles
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick(); tick(); tick();
        chk("wd_to3", b_to, 0);
        tick();
        chk("wd_to4", b_to, 1);
        tick(); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("wd_sticky", b_to, 1);
        chk("wd_to_a", a_to, 0);
        chk("wd_stall_a", a_stall, 11);
        chk("wd_stall_b", b_stall, 3);

        // reset while waiting aborts the wait
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        chk("rw_wait", a_wt, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1;
        chk("rw_pc", a_pc, 1);
        chk("rw_wait0", a_wt, 0);
        tick();
        chk("rw_to", b_to, 0);
        chk("rw_stall", a_stall, 0);
        chk("rw_flush", a_flush, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // flush counter saturation on the 2-bit instance
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        chk("sat_b", b_flush, 3);
        chk("sat_a", a_flush, 5);
        tick();

        armed = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
